// File: rtl/ram_arbiter_if.sv
// Two-requester RAM arbiter bus: request/response handshakes
// plus the split read/write RAM port the arbiter drives.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  req0_valid;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req0_ready;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;

  logic                  req1_valid;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_ready;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;

  logic [ADDR_WIDTH-1:0] RADDR;
  logic [ADDR_WIDTH-1:0] WADDR;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WE;
  logic [DATA_WIDTH-1:0] RDATA;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  RDATA,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output RADDR, WADDR, WDATA, WE
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output RDATA,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  RADDR, WADDR, WDATA, WE
  );
endinterface

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto a RAM with separate read/write
// ports; contention resolved by a toggling priority bit.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input logic       CLK,
  input logic       ASYNCRESETN,
  ram_arbiter_if.slave bus
);
  logic                  v0, v1, we0, we1;
  logic [ADDR_WIDTH-1:0] a0, a1;
  logic [DATA_WIDTH-1:0] d0, d1;

  logic prio_q, prio_d;
  logic tag_v_q, tag_v_d;
  logic tag_id_q, tag_id_d;
  logic cont, g0, g1;
  logic rg0, rg1, wg0, wg1;

  logic [ADDR_WIDTH-1:0] raddr, waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we;

  assign v0  = bus.req0_valid;
  assign v1  = bus.req1_valid;
  assign we0 = bus.req0_we;
  assign we1 = bus.req1_we;
  assign a0  = bus.req0_addr;
  assign a1  = bus.req1_addr;
  assign d0  = bus.req0_wdata;
  assign d1  = bus.req1_wdata;

  // Same op type, or read/write hitting one address, must serialise.
  always_comb begin
    cont = v0 & v1 & ((we0 == we1) | (a0 == a1));
    g0   = ASYNCRESETN & v0 & (~cont | ~prio_q);
    g1   = ASYNCRESETN & v1 & (~cont | prio_q);
    rg0  = g0 & ~we0;
    rg1  = g1 & ~we1;
    wg0  = g0 & we0;
    wg1  = g1 & we1;
    prio_d   = cont ? ~prio_q : prio_q;
    tag_v_d  = rg0 | rg1;
    tag_id_d = rg1;
  end

  always_comb begin
    raddr = '0;
    unique case (1'b1)
      rg0:     raddr = a0;
      rg1:     raddr = a1;
      default: raddr = '0;
    endcase
  end

  always_comb begin
    waddr = '0;
    wdata = '0;
    we    = 1'b0;
    unique case (1'b1)
      wg0: begin
        waddr = a0;
        wdata = d0;
        we    = 1'b1;
      end
      wg1: begin
        waddr = a1;
        wdata = d1;
        we    = 1'b1;
      end
      default: begin
        waddr = '0;
        wdata = '0;
        we    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      prio_q   <= 1'b0;
      tag_v_q  <= 1'b0;
      tag_id_q <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
    end
  end

  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;
  assign bus.RADDR      = raddr;
  assign bus.WADDR      = waddr;
  assign bus.WDATA      = wdata;
  assign bus.WE         = we;

  assign bus.rsp0_valid = tag_v_q & ~tag_id_q;
  assign bus.rsp1_valid = tag_v_q & tag_id_q;
  assign bus.rsp0_rdata =
    (tag_v_q & ~tag_id_q) ? bus.RDATA : '0;
  assign bus.rsp1_rdata =
    (tag_v_q & tag_id_q) ? bus.RDATA : '0;
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, RAM address width.
REQ-002 Parameter DATA_WIDTH, default 8, RAM data width.
REQ-003 CLK  input  1  single clock; rising edge; drives RAM RCLK and WCLK externally.
REQ-004 ASYNCRESETN  input  1  asynchronous active-low reset.
REQ-005 reqN_valid  input  1  (N=0,1) request present.
REQ-006 reqN_we  input  1  1 = write, 0 = read.
REQ-007 reqN_addr  input  ADDR_WIDTH  request address.
REQ-008 reqN_wdata  input  DATA_WIDTH  write data; ignored on reads.
REQ-009 reqN_ready  output  1  request accepted this cycle.
REQ-010 rspN_valid  output  1  read data valid for requester N.
REQ-011 rspN_rdata  output  DATA_WIDTH  read data.
REQ-012 RADDR  output  ADDR_WIDTH  RAM read address.
REQ-013 WADDR  output  ADDR_WIDTH  RAM write address.
REQ-014 WDATA  output  DATA_WIDTH  RAM write data.
REQ-015 WE  output  1  RAM write enable.
REQ-016 RDATA  input  DATA_WIDTH  RAM read data, valid one cycle after RADDR is sampled.

Function
REQ-017 A transfer SHALL occur on requester N in a cycle where reqN_valid && reqN_ready at the CLK rising edge.
REQ-018 reqN_ready SHALL be combinational from current inputs and state, asserted only when reqN_valid is 1.
REQ-019 Per cycle at most one read and at most one write SHALL be granted (separate RAM ports).
REQ-020 One read plus one write from different requesters to different addresses SHALL both be granted in the same cycle.
REQ-021 Two reads, two writes, or a read and write to the same address SHALL be a contention: only the requester selected by the priority bit is granted.
REQ-022 Priority bit prio (0 = requester 0 wins) SHALL update only on contention, to the losing requester's index; otherwise hold.
REQ-023 On granted write: WE=1, WADDR=addr, WDATA=wdata combinationally in the grant cycle; otherwise WE=0, WADDR=0, WDATA=0.
REQ-024 On granted read: RADDR=addr in the grant cycle; otherwise RADDR=0.
REQ-025 A read granted in cycle t SHALL set rspN_valid=1 for exactly cycle t+1, with rspN_rdata=RDATA that cycle.
REQ-026 rspN_rdata SHALL be 0 whenever rspN_valid=0.
REQ-027 A read tag register (valid bit + requester index) SHALL record the outstanding read; back-to-back reads every cycle SHALL be supported (full throughput, no bubble).
REQ-028 Ungranted requesters SHALL see reqN_ready=0 and MUST hold their request; no request is dropped.
REQ-029 A requester with valid held continuously SHALL be granted within 2 cycles (round-robin starvation bound).
REQ-030 No read-after-write forwarding: a read to an address written the previous cycle SHALL return whatever the RAM returns.

Reset
REQ-031 ASYNCRESETN low SHALL immediately clear prio=0, read tag valid=0, rsp0_valid=rsp1_valid=0, rspN_rdata=0.
REQ-032 During reset, reqN_ready=0, WE=0, RADDR=WADDR=WDATA=0.
REQ-033 A read outstanding when reset asserts SHALL produce no response after reset release.
REQ-034 Reset deassertion SHALL take effect at the next CLK rising edge; first grant possible in that cycle.

Verification
REQ-035 Reset then req0 write addr 0x10 data 0xA5, req1 idle -> req0_ready=1, WE=1, WADDR=0x10, WDATA=0xA5 same cycle; prio stays 0.
REQ-036 req0 read 0x10, req1 write 0x20 data 0x3C same cycle -> both ready=1; next cycle rsp0_valid=1, rsp0_rdata=RAM contents of 0x10 (0xA5).
REQ-037 Both read continuously (0x01, 0x02), prio=0 at start -> grants alternate 0,1,0,1; rsp valid alternates one cycle behind; prio toggles each cycle.
REQ-038 req0 write 0x40, req1 read 0x40 same cycle, prio=1 -> only req1 granted (read), prio=0; next cycle req0 write granted, rsp1_valid=1.
REQ-039 Read granted, ASYNCRESETN pulsed low mid-cycle before next edge -> rsp0_valid and rsp1_valid stay 0 after release; prio=0.
REQ-040 Both write continuously for 8 cycles -> each gets 4 grants, never 2 consecutive denials for either.
